// File: rtl/sms_pkg.sv
// Shared SMS card-model package: common limits and the pull-up input interpretation.
package sms_pkg;

    localparam int unsigned SMS_MAX_DELAY = 8;
    localparam int unsigned SMS_CNT_W     = 4;

    // Pulled-up input: a floating (z) or high pin reads 1, a low or unknown pin reads 0.
    function automatic logic sms_pull_up(input logic b);
        return (b === 1'b0 || b === 1'bx) ? 1'b0 : 1'b1;
    endfunction

endpackage

// File: rtl/sms_gate_chan.sv
// One NAND channel: pulled-up NAND, DELAY-stage pipeline, optional glitch filter
// (SMS_GLITCH_FILTER_EN), edge pulse and open-collector drive enable.
module sms_gate_chan
    import sms_pkg::*;
#(
    parameter int unsigned FANIN  = 3,
    parameter int unsigned DELAY  = 1,
    parameter int unsigned FILTER = 2,
    parameter logic        OC     = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [FANIN-1:0] in,
    output logic             out,
    output logic             out_oe,
    output logic             out_edge
);

    logic             raw;
    logic [DELAY-1:0] pipe;
    logic             p;
    logic             out_nxt;
    logic             out_q;

    // NAND of the pulled-up inputs: high when any input reads low.
    always_comb begin
        raw = 1'b0;
        for (int k = 0; k < int'(FANIN); k++) begin
            if (!sms_pull_up(in[k])) raw = 1'b1;
        end
    end

    // Propagation delay line; the oldest stage feeds the output logic.
    always_ff @(posedge clk) begin
        if (reset) pipe <= '0;
        else       pipe <= DELAY'({pipe, raw});
    end

    assign p = pipe[DELAY-1];

`ifdef SMS_GLITCH_FILTER_EN
    logic [SMS_CNT_W-1:0] cnt;
    logic [SMS_CNT_W-1:0] cnt_nxt;

    // Accept a new level only after FILTER consecutive differing samples.
    always_comb begin
        out_nxt = out;
        cnt_nxt = '0;
        if (p != out) begin
            if (cnt == SMS_CNT_W'(FILTER - 1)) out_nxt = p;
            else                               cnt_nxt = cnt + SMS_CNT_W'(1);
        end
    end

    // Filter run-length counter.
    always_ff @(posedge clk) begin
        if (reset) cnt <= '0;
        else       cnt <= cnt_nxt;
    end
`else
    // Unfiltered: the output simply registers the delayed raw result.
    always_comb begin
        out_nxt = p;
    end
`endif

    // Output level, its one-cycle-old copy and the change pulse derived from both.
    always_ff @(posedge clk) begin
        if (reset) begin
            out      <= 1'b0;
            out_q    <= 1'b0;
            out_edge <= 1'b0;
        end else begin
            out      <= out_nxt;
            out_q    <= out;
            out_edge <= out ^ out_q;
        end
    end

    // Open-collector channels only conduct while the output is high.
    assign out_oe = OC ? out : 1'b1;

endmodule

// File: rtl/sms_nand_bank.sv
// SMS NAND/inverter card: CHANNELS independent gates of FANIN inputs each.
// Glitch filter is compiled in when SMS_GLITCH_FILTER_EN is defined.
module sms_nand_bank
    import sms_pkg::*;
#(
    parameter int unsigned          CHANNELS = 3,
    parameter int unsigned          FANIN    = 3,
    parameter int unsigned          DELAY    = 1,
    parameter int unsigned          FILTER   = 2,
    parameter logic [CHANNELS-1:0]  OC_MASK  = {CHANNELS{1'b0}}
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS*FANIN-1:0] in,
    output logic [CHANNELS-1:0]       out,
    output logic [CHANNELS-1:0]       out_oe,
    output logic [CHANNELS-1:0]       out_edge
);

    // One gate channel per output bit.
    for (genvar i = 0; i < int'(CHANNELS); i++) begin : g_chan
        sms_gate_chan #(
            .FANIN  (FANIN),
            .DELAY  (DELAY),
            .FILTER (FILTER),
            .OC     (OC_MASK[i])
        ) u_chan (
            .clk      (clk),
            .reset    (reset),
            .in       (in[i*FANIN +: FANIN]),
            .out      (out[i]),
            .out_oe   (out_oe[i]),
            .out_edge (out_edge[i])
        );
    end

endmodule

// File: tb/tb_sms_nand_bank.sv
// Self-checking bench for sms_nand_bank: directed scenarios plus randomized bursts
// compared against a behavioural model of the card.
module tb_sms_nand_bank;

    localparam int unsigned CH = 3;
    localparam int unsigned FI = 3;
    localparam int unsigned DL = 2;
    localparam int unsigned FL = 3;
    localparam logic [2:0]  OCM = 3'b100;
`ifdef SMS_GLITCH_FILTER_EN
    localparam bit FILT_EN = 1'b1;
`else
    localparam bit FILT_EN = 1'b0;
`endif
    localparam int LAT = FILT_EN ? int'(DL + FL) : int'(DL + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic [8:0]    in;
    logic [2:0]    out;
    logic [2:0]    out_oe;
    logic [2:0]    out_edge;

    int errors = 0;
    int checks = 0;

    // Model state: delayed raw samples, output level, previous level, pulse, run length.
    bit m_pq[CH][$];
    bit m_out[CH];
    bit m_prev[CH];
    bit m_edge[CH];
    int m_run[CH];

    sms_nand_bank #(
        .CHANNELS (CH),
        .FANIN    (FI),
        .DELAY    (DL),
        .FILTER   (FL),
        .OC_MASK  (OCM)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in       (in),
        .out      (out),
        .out_oe   (out_oe),
        .out_edge (out_edge)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance the model by one clock edge with the given reset and input values.
    task model_step(input bit rst, input logic [8:0] vin);
        bit raw, p;
        for (int c = 0; c < int'(CH); c++) begin
            if (rst) begin
                m_pq[c].delete();
                for (int d = 0; d < int'(DL); d++) m_pq[c].push_back(1'b0);
                m_out[c]  = 1'b0;
                m_prev[c] = 1'b0;
                m_edge[c] = 1'b0;
                m_run[c]  = 0;
            end else begin
                raw = ~(&vin[c*FI +: FI]);
                p   = m_pq[c].pop_front();
                m_pq[c].push_back(raw);
                m_edge[c] = m_out[c] ^ m_prev[c];
                m_prev[c] = m_out[c];
                if (FILT_EN) begin
                    if (p != m_out[c]) begin
                        m_run[c]++;
                        if (m_run[c] >= int'(FL)) begin
                            m_out[c] = p;
                            m_run[c] = 0;
                        end
                    end else begin
                        m_run[c] = 0;
                    end
                end else begin
                    m_out[c] = p;
                end
            end
        end
    endtask

    task automatic compare_model(input string tag);
        logic [2:0] eo, eoe, ee;
        for (int c = 0; c < int'(CH); c++) begin
            eo[c]  = m_out[c];
            eoe[c] = OCM[c] ? m_out[c] : 1'b1;
            ee[c]  = m_edge[c];
        end
        check({tag, ".out"},  32'(out),      32'(eo));
        check({tag, ".oe"},   32'(out_oe),   32'(eoe));
        check({tag, ".edge"}, 32'(out_edge), 32'(ee));
    endtask

    // Drive one cycle from a negedge, let the edge happen, sample at the next negedge.
    task automatic cycle(input bit rst, input logic [8:0] vin, input string tag);
        reset = rst;
        in    = vin;
        @(posedge clk);
        model_step(rst, vin);
        @(negedge clk);
        compare_model(tag);
    endtask

    initial begin
        bit         v[CH];
        int         hold[CH];
        logic [8:0] vin;

        reset = 1'b1;
        in    = 9'h1FF;
        @(negedge clk);

        // Reset with all inputs released.
        cycle(1'b1, 9'h1FF, "rst");
        cycle(1'b1, 9'h1FF, "rst");
        check("rst_out",  32'(out),      32'h0);
        check("rst_oe",   32'(out_oe),   32'h3);
        check("rst_edge", 32'(out_edge), 32'h0);

        // in[1] held low: channel 0 rises after the full latency, pulse one cycle later.
        for (int k = 0; k < 9; k++) begin
            cycle(1'b0, 9'h1FD, "hold1");
            check("hold1_out0",  32'(out[0]),      32'((k + 1) >= LAT));
            check("hold1_edge0", 32'(out_edge[0]), 32'((k + 1) == LAT + 1));
        end

        // Two-cycle low pulse on in[4]: rejected when filtered, passed through otherwise.
        cycle(1'b1, 9'h1FF, "rst");
        for (int k = 0; k < 10; k++) begin
            cycle(1'b0, (k < 2) ? 9'h1EF : 9'h1FF, "glitch");
            check("glitch_out1", 32'(out[1]),
                  32'(!FILT_EN && ((k + 1) == int'(DL) + 1 || (k + 1) == int'(DL) + 2)));
        end

        // Open-collector channel 2: drive enable follows the output level.
        cycle(1'b1, 9'h1FF, "rst");
        for (int k = 0; k < 8; k++) cycle(1'b0, 9'h0FF, "oc_on");
        check("oc_on_out2", 32'(out[2]),    32'h1);
        check("oc_on_oe2",  32'(out_oe[2]), 32'h1);
        for (int k = 0; k < 6; k++) begin
            cycle(1'b0, 9'h1FF, "oc_off");
            check("oc_off_out2", 32'(out[2]),    32'((k + 1) < LAT));
            check("oc_off_oe2",  32'(out_oe[2]), 32'((k + 1) < LAT));
        end

        // Reset lands one edge before the change would be accepted.
        cycle(1'b1, 9'h1FF, "rst");
        for (int k = 0; k < 4; k++) cycle(1'b0, 9'h1FD, "pre_rst");
        cycle(1'b1, 9'h1FD, "mid_rst");
        for (int k = 0; k < 6; k++) begin
            cycle(1'b0, 9'h1FF, "post_rst");
            check("post_rst_out",  32'(out),      32'h0);
            check("post_rst_edge", 32'(out_edge), 32'h0);
        end

        // Randomized bursts per channel with occasional resets.
        for (int c = 0; c < int'(CH); c++) begin
            v[c]    = 1'b1;
            hold[c] = 0;
        end
        for (int n = 0; n < 400; n++) begin
            vin = 9'h1FF;
            for (int c = 0; c < int'(CH); c++) begin
                if (hold[c] == 0) begin
                    v[c]    = 1'($urandom_range(0, 1));
                    hold[c] = int'($urandom_range(1, 6));
                end
                hold[c]--;
                if (!v[c]) vin[c*FI + int'($urandom_range(0, FI - 1))] = 1'b0;
            end
            cycle($urandom_range(0, 49) == 0, vin, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
